// File: rtl/vector_magnitude_seq.sv
// Bit-serial Euclidean magnitude floor(sqrt(x^2+y^2)) of two signed deltas, valid/ready on both sides.
// Build option: define MAG_ROUND_EN to round the result to nearest instead of flooring.
module vector_magnitude_seq #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [W:0] x_axis,
    input  logic [W:0] y_axis,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [W:0] z_mag,
    output logic       z_sat,
    output logic       busy
);
    localparam int RW = 2 * W + 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] ONE_W = 1;

    // Handshakes: a sample transfers on a clk edge where in_valid && in_ready;
    // a result transfers on a clk edge where out_valid && out_ready.
    typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    ax_q, ay_q;
    logic            sat_q;
    logic [RW-1:0]   rad_q;
    logic [W:0]      q_q;
    logic [W+1:0]    rem_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      top2;
    logic [W+3:0]    trial_a, trial_b;
    logic            ge;
    logic [W+1:0]    diff, rem_nxt;
    logic [W:0]      q_nxt, result;
    logic            last_iter;

    function automatic logic [W-1:0] abs_sat(input logic [W:0] v);
        if (v == {1'b1, {W{1'b0}}}) return {W{1'b1}};
        if (v[W]) return ~v[W-1:0] + ONE_W;
        return v[W-1:0];
    endfunction

    // One restoring root step: bring down two radicand bits, try subtracting 4q+1.
    assign top2      = rad_q[RW-1 -: 2];
    assign trial_a   = {rem_q, top2};
    assign trial_b   = {1'b0, q_q, 2'b01};
    assign ge        = (trial_a >= trial_b);
    assign diff      = trial_a[W+1:0] - trial_b[W+1:0];
    assign rem_nxt   = ge ? diff : trial_a[W+1:0];
    assign q_nxt     = {q_q[W-1:0], ge};
    assign last_iter = (cnt_q == CW'(W));

`ifdef MAG_ROUND_EN
    localparam logic [W:0] ONE_Q = 1;
    // rem > q means R >= q^2 + q + 1, i.e. sqrt(R) lies above q + 0.5.
    assign result = (rem_nxt > {1'b0, q_nxt}) ? q_nxt + ONE_Q : q_nxt;
`else
    assign result = q_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SQ;
            SQ:      state_d = ROOT;
            ROOT:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ax_q  <= '0;
            ay_q  <= '0;
            sat_q <= 1'b0;
            rad_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            z_mag <= '0;
            z_sat <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    ax_q  <= abs_sat(x_axis);
                    ay_q  <= abs_sat(y_axis);
                    sat_q <= (x_axis == {1'b1, {W{1'b0}}}) || (y_axis == {1'b1, {W{1'b0}}});
                end
                SQ: begin
                    rad_q <= RW'(ax_q) * RW'(ax_q) + RW'(ay_q) * RW'(ay_q);
                    q_q   <= '0;
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                ROOT: begin
                    rad_q <= rad_q << 2;
                    q_q   <= q_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        z_mag <= result;
                        z_sat <= sat_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_magnitude_seq.sv
// Randomised scoreboard bench for vector_magnitude_seq (W=8); reference is a plain integer sqrt search.
module tb_vector_magnitude_seq;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [W:0] x_axis = '0;
    logic [W:0] y_axis = '0;
    logic       in_ready, out_valid, z_sat, busy;
    logic [W:0] z_mag;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];
    bit rand_rdy = 1'b0;

    vector_magnitude_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_axis(x_axis), .y_axis(y_axis), .out_valid(out_valid),
        .out_ready(out_ready), .z_mag(z_mag), .z_sat(z_sat), .busy(busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {sat, magnitude} from the arithmetic definition.
    function automatic logic [W+1:0] ref_model(input logic [W:0] x, input logic [W:0] y);
        int xs, ys, ax, ay, r, q;
        bit sat;
        xs  = x[W] ? int'(x) - (1 << (W + 1)) : int'(x);
        ys  = y[W] ? int'(y) - (1 << (W + 1)) : int'(y);
        sat = (xs == -(1 << W)) || (ys == -(1 << W));
        ax  = (xs < 0) ? -xs : xs;
        ay  = (ys < 0) ? -ys : ys;
        if (ax > (1 << W) - 1) ax = (1 << W) - 1;
        if (ay > (1 << W) - 1) ay = (1 << W) - 1;
        r = ax * ax + ay * ay;
        q = 0;
        while ((q + 1) * (q + 1) <= r) q++;
`ifdef MAG_ROUND_EN
        if (r - q * q > q) q++;
`endif
        return {sat, q[W:0]};
    endfunction

    // Driver: present a sample, push its expectation at the accept edge.
    task automatic send(input logic [W:0] x, input logic [W:0] y);
        int n = 0;
        x_axis   = x;
        y_axis   = y;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_model(x, y));
                break;
            end
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_axis   = W'($urandom);
        y_axis   = W'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 50);
    endtask

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [W+1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("z_mag", int'(z_mag), int'(exp[W:0]));
                    chk("z_sat", int'(z_sat), int'(exp[W+1]));
                end
            end
        end
    end

    initial begin
        int n;
        logic [W:0] hold;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_z_mag", int'(z_mag), 0);
        chk("rst_z_sat", int'(z_sat), 0);
        chk("rst_busy", int'(busy), 0);

        // Latency with 3,4
        out_ready = 1'b1;
        send(9'd3, 9'd4);
        chk("busy_after_accept", int'(busy), 1);
        wait_out_valid(n);
        chk("latency", n, W + 2);
        wait_drain();

        // Directed values
        send(9'h1FD, 9'd4);
        send(9'd255, 9'd255);
        send(9'd2, 9'd3);
        send(9'd1, 9'd1);
        send(9'h100, 9'd0);
        send(9'd0, 9'd0);
        send(9'd0, 9'h100);
        send(9'h100, 9'h100);
        wait_drain();

        // Output stall: result held, further samples refused
        out_ready = 1'b0;
        send(9'd200, 9'h1C0);
        wait_out_valid(n);
        chk("stall_out_valid", int'(out_valid), 1);
        hold = z_mag;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            x_axis   = 9'd7;
            y_axis   = 9'd9;
            @(posedge clk);
            #1;
            chk("stall_z_mag", int'(z_mag), int'(hold));
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid_hold", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
        send(9'd2, 9'd3);
        wait_drain();

        // Reset during the 5th ROOT cycle
        send(9'd100, 9'd50);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_z_mag", int'(z_mag), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        send(9'd6, 9'd8);
        wait_drain();

        // Random samples with random stalls on both sides
        rand_rdy = 1'b1;
        for (int i = 0; i < 511; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        repeat (20) @(posedge clk);
        #1;
        chk("final_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vector_magnitude_seq.md
Name: vector_magnitude_seq

Overview:
- Sequential successor to the combinational pointer-delta magnitude unit.
- Takes a pair of signed PS/2 movement deltas (X, Y) and returns the integer Euclidean magnitude floor(sqrt(x²+y²)).
- Data width is parametrised; the root is computed bit-serially, one result bit per clock.
- Uses valid/ready handshakes so it sits between the PS/2 packet decoder and the cursor-speed / acceleration logic.

Parameters:
- W, 8: magnitude bits of each delta. Inputs are W+1-bit two's complement; the result is W+1 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  x_axis/y_axis hold a new sample
- in_ready  output  1  block can accept a sample
- x_axis  input  W+1  X delta, two's complement, sign in bit W
- y_axis  input  W+1  Y delta, two's complement, sign in bit W
- out_valid  output  1  z_mag/z_sat are valid
- out_ready  input  1  consumer accepts the result
- z_mag  output  W+1  integer magnitude
- z_sat  output  1  at least one input was -2^W and was saturated
- busy  output  1  a computation is in progress (state is not IDLE)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; in_ready=1; out_valid=0; z_mag=0; z_sat=0; busy=0; all internal registers cleared. Reset overrides every other event, including mid-computation and pending output; any in-flight sample is discarded.
- States: IDLE -> SQ -> ROOT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 the block captures ax=|x_axis| and ay=|y_axis| as W-bit values.
  - Input value -2^W (e.g. 9'h100 for W=8) saturates to 2^W-1; the saturation flag is latched.
  - Next state: SQ.
- SQ (1 cycle):
  - radicand R = ax*ax + ay*ay, 2W+2 bits, zero-extended; no overflow is possible.
  - Root q, remainder rem and iteration counter are cleared. Next state: ROOT.
- ROOT (exactly W+1 cycles):
  - Restoring digit-by-digit square root. Each cycle consumes the top 2 bits of R (shift R left by 2).
  - Trial value t = {rem, top2} - {q, 2'b01}.
  - If t >= 0: rem=t and q={q,1}. Otherwise: rem={rem, top2} and q={q,0}.
  - After the W+1th iteration: q = floor(sqrt(R)), loaded into z_mag; z_sat is loaded; out_valid=1; next state DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - z_mag/z_sat are held stable until out_ready=1. On that edge out_valid drops and the state returns to IDLE.
  - in_valid presented in DONE is ignored; there is no accept on the same edge. Throughput is at most one sample per W+4 cycles.
- Latency: accept edge at cycle n -> out_valid high from edge n+W+2 (10 cycles for W=8).
- in_ready is combinational from state only, never from in_valid. out_valid is registered.
- Inputs are sampled only on the accept edge; later changes on x_axis/y_axis have no effect.
- out_ready asserted while out_valid=0 has no effect.
- Zero inputs complete through the normal sequence with z_mag=0; there is no shortcut.

Optional Feature:
- Macro: MAG_ROUND_EN.
- Defined: the last ROOT cycle rounds to nearest. If the final remainder rem > q, z_mag = q+1; otherwise z_mag = q. This gives round(sqrt(R)), with ties impossible for integers. Latency is unchanged. The result stays below 2^(W+1) for all inputs.
- Undefined: z_mag = floor(sqrt(R)). The rounding comparator and incrementer are not synthesised.

Test Plan (W=8):
- x=3, y=4, out_ready=1 -> out_valid exactly 10 cycles after accept; z_mag=5, z_sat=0; identical result for x=9'h1FD (-3), y=4.
- x=255, y=255 -> z_mag=360 floor, 361 with MAG_ROUND_EN. x=2, y=3 -> 3 floor, 4 rounded. x=1, y=1 -> 1 in both builds.
- x=9'h100, y=0 -> z_mag=255, z_sat=1. Then x=0, y=0 -> z_mag=0, z_sat=0.
- Hold out_ready=0 for 20 cycles after out_valid -> z_mag stable, in_ready=0, and a new in_valid is not accepted. Release -> IDLE the next cycle, then a new accept.
- Assert rst during the 5th ROOT cycle -> next edge: out_valid=0, z_mag=0, in_ready=1. The next sample computes correctly.
- 511 random x/y pairs with random in_valid/out_ready stalls -> every result matches a software floor/round integer sqrt; no sample is lost or duplicated.
